mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu through a fixed-latency busy window.
- Serves mfhi/mflo/mthi/mtlo.
- Produces the MD stall request that the hazard unit ORs into its global Stall.

---
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// HI/LO owner and fixed-latency multiply/divide sequencer for the E stage.
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_IsMD,
   output logic        E_Busy,
   output logic        E_Start,
   output logic        Stall_MD,
   output logic [31:0] E_MDOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
   logic [31:0] pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;
   logic        pend_wr_reg, pend_wr_next;

   logic        is_mult, is_start;
   logic [63:0] smul, umul, res;
   logic        res_wr;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

   always_comb begin
      is_mult = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
`ifdef MDU_MADD_EN
      is_mult = is_mult || (E_MDOp == 4'd9) || (E_MDOp == 4'd10);
`endif
      is_start = is_mult || (E_MDOp == 4'd3) || (E_MDOp == 4'd4);
   end

   assign smul = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
   assign umul = {32'd0, E_A} * {32'd0, E_B};

   // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
   assign a_mag = E_A[31] ? (~E_A + 32'd1) : E_A;
   assign b_mag = E_B[31] ? (~E_B + 32'd1) : E_B;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign div_q = (E_A[31] ^ E_B[31]) ? (~q_mag + 32'd1) : q_mag;
   assign div_r = E_A[31] ? (~r_mag + 32'd1) : r_mag;

   always_comb begin
      res    = 64'd0;
      res_wr = 1'b1;
      case (E_MDOp)
         4'd1: res = smul;
         4'd2: res = umul;
         4'd3: begin
            res    = {div_r, div_q};
            res_wr = (E_B != 32'd0);
         end
         4'd4: begin
            res    = {E_A % E_B, E_A / E_B};
            res_wr = (E_B != 32'd0);
         end
`ifdef MDU_MADD_EN
         4'd9:  res = {hi_reg, lo_reg} + smul;
         4'd10: res = {hi_reg, lo_reg} + umul;
`endif
         default: res = 64'd0;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      pend_hi_next = pend_hi_reg;
      pend_lo_next = pend_lo_reg;
      pend_wr_next = pend_wr_reg;
      case (state_reg)
         IDLE: begin
            if (is_start) begin
               pend_hi_next = res[63:32];
               pend_lo_next = res[31:0];
               pend_wr_next = res_wr;
               cnt_next     = is_mult ? MULT_CNT : DIV_CNT;
               state_next   = BUSY;
            end else if (E_MDOp == 4'd5) begin
               hi_next = E_A;
            end else if (E_MDOp == 4'd6) begin
               lo_next = E_A;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = IDLE;
               if (pend_wr_reg) begin
                  hi_next = pend_hi_reg;
                  lo_next = pend_lo_reg;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= 4'd0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
         pend_wr_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
         pend_hi_reg <= pend_hi_next;
         pend_lo_reg <= pend_lo_next;
         pend_wr_reg <= pend_wr_next;
      end
   end

   assign E_Busy   = (state_reg == BUSY);
   assign E_Start  = is_start && (state_reg == IDLE);
   assign Stall_MD = D_IsMD && (E_Busy || E_Start);
   assign E_MDOut  = (E_MDOp == 4'd7) ? hi_reg :
                     (E_MDOp == 4'd8) ? lo_reg : 32'd0;
   assign HI       = hi_reg;
   assign LO       = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed plan cases followed by random ops,
// all compared against a cycle-level arithmetic reference model.
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  E_MDOp;
   logic [31:0] E_A, E_B;
   logic        D_IsMD;
   logic        E_Busy, E_Start, Stall_MD;
   logic [31:0] E_MDOut, HI, LO;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pwr;
   int          m_left;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
      .D_IsMD(D_IsMD), .E_Busy(E_Busy), .E_Start(E_Start), .Stall_MD(Stall_MD),
      .E_MDOut(E_MDOut), .HI(HI), .LO(LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_start(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
      if (op == 4'd9 || op == 4'd10) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Reference arithmetic using 64-bit integer math.
   task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_pwr = 1'b1;
      p = 64'd0;
      case (op)
         4'd1: p = 64'(sa * sb);
         4'd2: p = {32'd0, a} * {32'd0, b};
         4'd3: begin
            if (b == 32'd0) m_pwr = 1'b0;
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         4'd4: begin
            if (b == 32'd0) m_pwr = 1'b0;
            else p = {a % b, a / b};
         end
         4'd9:  p = {m_hi, m_lo} + 64'(sa * sb);
         4'd10: p = {m_hi, m_lo} + {32'd0, a} * {32'd0, b};
         default: p = 64'd0;
      endcase
      m_phi = p[63:32];
      m_plo = p[31:0];
   endtask

   task automatic model_reset();
      m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
      m_pwr = 1'b0; m_left = 0;
   endtask

   // One pipeline cycle: drive at negedge, check, then advance the model on the edge.
   task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic d);
      logic busy, st;
      logic [31:0] mdo;
      E_MDOp = op; E_A = a; E_B = b; D_IsMD = d;
      #1;
      busy = (m_left > 0);
      st   = !busy && m_start(op);
      mdo  = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
      chk("busy",  {31'd0, E_Busy},   {31'd0, busy});
      chk("start", {31'd0, E_Start},  {31'd0, st});
      chk("stall", {31'd0, Stall_MD}, {31'd0, d && (busy || st)});
      chk("mdout", E_MDOut, mdo);
      chk("hi",    HI, m_hi);
      chk("lo",    LO, m_lo);
      @(posedge clk);
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pwr) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (m_start(op)) begin
         model_compute(op, a, b);
         m_left = (op == 4'd3 || op == 4'd4) ? 10 : 5;
      end else if (op == 4'd5) begin
         m_hi = a;
      end else if (op == 4'd6) begin
         m_lo = a;
      end
      @(negedge clk);
   endtask

   // Issue an op, then idle 14 cycles with fresh random operands; returns observed busy count.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic d, output int nbusy);
      nbusy = 0;
      step(op, a, b, d);
      for (int i = 0; i < 14; i++) begin
         if (E_Busy) nbusy++;
         step(4'd0, $urandom, $urandom, d);
      end
      $display("op %0d a=%h b=%h -> busy %0d cycles, HI=%h LO=%h", op, a, b, nbusy, HI, LO);
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   int nb;

   initial begin
      reset = 1'b1; E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0; D_IsMD = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_busy", {31'd0, E_Busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Multiply
      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
      chk("mult_busy_cycles", 32'(nb), 32'd5);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);
      run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
      chk("multu_hi", HI, 32'h0000_0002);
      chk("multu_lo", LO, 32'hFFFF_FFFA);

      // Divide
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
      chk("div_busy_cycles", 32'(nb), 32'd10);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
      chk("divovf_lo", LO, 32'h8000_0000);
      chk("divovf_hi", HI, 32'd0);

      // Divide by zero keeps HI/LO
      step(4'd5, 32'h11, 32'd0, 1'b0);
      step(4'd6, 32'h22, 32'd0, 1'b0);
      run_op(4'd4, 32'h1234, 32'd0, 1'b0, nb);
      chk("div0_busy_cycles", 32'(nb), 32'd10);
      chk("div0_hi", HI, 32'h11);
      chk("div0_lo", LO, 32'h22);
      E_MDOp = 4'd7; #1;
      chk("mfhi_out", E_MDOut, 32'h11);
      @(negedge clk);

      // Stall window and ignored mtlo while busy
      step(4'd1, 32'd7, 32'd6, 1'b1);
      step(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
      for (int i = 0; i < 6; i++) step(4'd0, $urandom, $urandom, 1'b1);
      chk("stall_after", {31'd0, Stall_MD}, 32'd0);
      chk("busy_mtlo_lo", LO, 32'd42);
      chk("busy_mtlo_hi", HI, 32'd0);

      // Reset in busy cycle 3 of a divide
      step(4'd5, 32'h55, 32'd0, 1'b0);
      step(4'd6, 32'h66, 32'd0, 1'b0);
      step(4'd3, 32'd100, 32'd7, 1'b0);
      step(4'd0, 32'd0, 32'd0, 1'b0);
      step(4'd0, 32'd0, 32'd0, 1'b0);
      reset = 1'b1; #1;
      chk("midrst_busy", {31'd0, E_Busy}, 32'd0);
      chk("midrst_hi", HI, 32'd0);
      chk("midrst_lo", LO, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
      chk("postrst_hi", HI, 32'd0);
      chk("postrst_lo", LO, 32'd0);
      $display("reset mid-divide: HI=%h LO=%h", HI, LO);

      // madd/maddu accumulate
      step(4'd5, 32'd0, 32'd0, 1'b0);
      step(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op(4'd10, 32'd1, 32'd1, 1'b1, nb);
`ifdef MDU_MADD_EN
      chk("maddu_busy_cycles", 32'(nb), 32'd5);
      chk("maddu_hi", HI, 32'd1);
      chk("maddu_lo", LO, 32'd0);
`else
      chk("maddu_busy_cycles", 32'(nb), 32'd0);
      chk("maddu_hi", HI, 32'd0);
      chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
         step(op, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 12; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
      $display("random phase done: HI=%h LO=%h", HI, LO);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
